// File: rtl/hdmi_pkg.sv
// HDMI data-island packet parser shared definitions.
// Packet type codes, BCH ECC step function and FSM states.
package hdmi_pkg;

  localparam logic [7:0] PT_NULL = 8'h00;
  localparam logic [7:0] PT_ACR  = 8'h01;
  localparam logic [7:0] PT_AS   = 8'h02;
  localparam logic [7:0] PT_GCP  = 8'h03;
  localparam logic [7:0] PT_VSIF = 8'h81;
  localparam logic [7:0] PT_AVI  = 8'h82;
  localparam logic [7:0] PT_SPD  = 8'h83;
  localparam logic [7:0] PT_AIF  = 8'h84;

  localparam logic [7:0] ECC_POLY = 8'h83;

  localparam logic [5:0] IDX_HDR_ECC = 6'd3;
  localparam logic [5:0] IDX_LAST    = 6'd35;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BODY,
    DONE
  } state_t;

  function automatic logic [7:0] ecc_byte(
    input logic [7:0] ecc,
    input logic [7:0] data
  );
    logic [7:0] e;
    logic       fb;
    e = ecc;
    for (int i = 0; i < 8; i++) begin
      fb = e[0] ^ data[i];
      e  = e >> 1;
      if (fb) e = e ^ ECC_POLY;
    end
    return e;
  endfunction

endpackage

// File: rtl/hdmi_bch_accum.sv
// 8-bit BCH ECC accumulator, LSB-first per byte.
// clr with en restarts the sum from this byte.
module hdmi_bch_accum
  import hdmi_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] ecc
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ecc <= '0;
    end else if (en) begin
      ecc <= ecc_byte(clr ? 8'h00 : ecc, din);
    end else if (clr) begin
      ecc <= '0;
    end
  end

endmodule

// File: rtl/hdmi_packet_parser.sv
// Byte-serial HDMI data-island packet receiver.
// Checks header/body ECC and InfoFrame checksum, decodes GCP/ACR/AVI.
module hdmi_packet_parser
  import hdmi_pkg::*;
#(
  parameter int MAX_IF_LEN = 27
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  input  logic        PKT_START,
  output logic        PKT_VALID,
  output logic [7:0]  PKT_TYPE,
  output logic        HDR_ECC_ERR,
  output logic [3:0]  BODY_ECC_ERR,
  output logic        CSUM_ERR,
  output logic        ABORT,
  output logic        AVMUTE,
  output logic [19:0] ACR_N,
  output logic [19:0] ACR_CTS,
  output logic [6:0]  AVI_VIC,
  output logic [1:0]  AVI_Y
);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic       abort_d, done_d;

  logic       start, take, in_hdr, in_body;
  logic [4:0] rel;
  logic [1:0] sub;
  logic [2:0] off;
  logic [4:0] pb_j;

  logic [7:0] hb0_q;
  logic [4:0] len_q;
  logic [7:0] sum_q;
  logic       hdr_err_q;
  logic [3:0] berr_q, berr_now;
  logic [7:0] sp0_q [0:7];

  logic       hdr_en;
  logic [7:0] hdr_ecc;
  logic [3:0] sp_en, sp_clr;
  logic [7:0] sp_ecc [0:3];
  logic       csum_err, pkt_ok;

  assign start   = BYTE_VALID & PKT_START;
  assign take    = BYTE_VALID & ~PKT_START;
  assign in_hdr  = take && (state_q == HEADER);
  assign in_body = take && (state_q == BODY);

  // Body position: subpacket number and byte within it (7 = ECC byte)
  assign rel  = 5'(idx_q - 6'd4);
  assign sub  = rel[4:3];
  assign off  = rel[2:0];
  assign pb_j = {3'b000, sub} * 5'd7 + {2'b00, off};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abort_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEADER;
          idx_d   = 6'd1;
        end
      end
      HEADER: begin
        if (start) begin
          abort_d = 1'b1;
          idx_d   = 6'd1;
        end else if (take) begin
          if (idx_q == IDX_HDR_ECC) state_d = BODY;
          idx_d = idx_q + 6'd1;
        end
      end
      BODY: begin
        if (start) begin
          abort_d = 1'b1;
          state_d = HEADER;
          idx_d   = 6'd1;
        end else if (take) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = HEADER;
          idx_d   = 6'd1;
        end else begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign hdr_en = start | (in_hdr && (idx_q != IDX_HDR_ECC));

  always_comb begin
    sp_en  = '0;
    sp_clr = '0;
    for (int k = 0; k < 4; k++) begin
      sp_en[k]  = in_body && (sub == 2'(k)) && (off != 3'd7);
      sp_clr[k] = sp_en[k] && (off == 3'd0);
    end
  end

  hdmi_bch_accum u_hdr_ecc (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (start),
    .en   (hdr_en),
    .din  (BYTE_IN),
    .ecc  (hdr_ecc)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sp
    hdmi_bch_accum u_sp_ecc (
      .CLK  (CLK),
      .RSTN (RSTN),
      .clr  (sp_clr[k]),
      .en   (sp_en[k]),
      .din  (BYTE_IN),
      .ecc  (sp_ecc[k])
    );
  end

  // Subpacket 3 is checked on byte 35, so its bit is folded in combinationally
  always_comb begin
    berr_now = berr_q;
    if (in_body && (off == 3'd7)) begin
      berr_now[sub] = (BYTE_IN != sp_ecc[sub]);
    end
  end

  assign csum_err = hb0_q[7] &&
                    ((sum_q != 8'h00) ||
                     (int'({27'd0, len_q}) > MAX_IF_LEN));
  assign pkt_ok   = !hdr_err_q && (berr_now == 4'd0) && !csum_err;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hb0_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      hdr_err_q <= 1'b0;
      berr_q    <= '0;
      for (int i = 0; i < 8; i++) sp0_q[i] <= '0;
    end else begin
      berr_q <= berr_now;
      if (start) begin
        hb0_q <= BYTE_IN;
        sum_q <= BYTE_IN;
      end else if (in_hdr && (idx_q != IDX_HDR_ECC)) begin
        sum_q <= sum_q + BYTE_IN;
      end else if (in_body && (off != 3'd7) && (pb_j <= len_q)) begin
        sum_q <= sum_q + BYTE_IN;
      end
      if (in_hdr && (idx_q == 6'd2)) len_q <= BYTE_IN[4:0];
      if (in_hdr && (idx_q == IDX_HDR_ECC)) begin
        hdr_err_q <= (BYTE_IN != hdr_ecc);
      end
      if (sp_en[0]) sp0_q[off] <= BYTE_IN;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PKT_VALID    <= 1'b0;
      PKT_TYPE     <= '0;
      HDR_ECC_ERR  <= 1'b0;
      BODY_ECC_ERR <= '0;
      CSUM_ERR     <= 1'b0;
      ABORT        <= 1'b0;
      AVMUTE       <= 1'b0;
      ACR_N        <= '0;
      ACR_CTS      <= '0;
      AVI_VIC      <= '0;
      AVI_Y        <= '0;
    end else begin
      PKT_VALID <= done_d;
      ABORT     <= abort_d;
      if (done_d) begin
        PKT_TYPE     <= hb0_q;
        HDR_ECC_ERR  <= hdr_err_q;
        BODY_ECC_ERR <= berr_now;
        CSUM_ERR     <= csum_err;
        if (pkt_ok) begin
          unique case (1'b1)
            (hb0_q == PT_GCP): begin
              if (sp0_q[0][0] && !sp0_q[0][4]) AVMUTE <= 1'b1;
              else if (sp0_q[0][4] && !sp0_q[0][0]) AVMUTE <= 1'b0;
            end
            (hb0_q == PT_ACR): begin
              ACR_CTS <= {sp0_q[1][3:0], sp0_q[2], sp0_q[3]};
              ACR_N   <= {sp0_q[4][3:0], sp0_q[5], sp0_q[6]};
            end
            (hb0_q == PT_AVI): begin
              AVI_Y   <= sp0_q[1][6:5];
              AVI_VIC <= sp0_q[4][6:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_packet_parser.sv
// Scoreboard bench for hdmi_packet_parser.
// Packets built with bench-side ECC/checksum; results queued and compared.
module tb_hdmi_packet_parser;

  localparam int MAX_IF_LEN = 27;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        PKT_START;
  logic        PKT_VALID;
  logic [7:0]  PKT_TYPE;
  logic        HDR_ECC_ERR;
  logic [3:0]  BODY_ECC_ERR;
  logic        CSUM_ERR;
  logic        ABORT;
  logic        AVMUTE;
  logic [19:0] ACR_N;
  logic [19:0] ACR_CTS;
  logic [6:0]  AVI_VIC;
  logic [1:0]  AVI_Y;

  hdmi_packet_parser #(.MAX_IF_LEN(MAX_IF_LEN)) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .BYTE_IN      (BYTE_IN),
    .BYTE_VALID   (BYTE_VALID),
    .PKT_START    (PKT_START),
    .PKT_VALID    (PKT_VALID),
    .PKT_TYPE     (PKT_TYPE),
    .HDR_ECC_ERR  (HDR_ECC_ERR),
    .BODY_ECC_ERR (BODY_ECC_ERR),
    .CSUM_ERR     (CSUM_ERR),
    .ABORT        (ABORT),
    .AVMUTE       (AVMUTE),
    .ACR_N        (ACR_N),
    .ACR_CTS      (ACR_CTS),
    .AVI_VIC      (AVI_VIC),
    .AVI_Y        (AVI_Y)
  );

  typedef struct packed {
    logic [7:0]  typ;
    logic        hdr;
    logic [3:0]  body;
    logic        csum;
    logic        avm;
    logic [19:0] n;
    logic [19:0] cts;
    logic [6:0]  vic;
    logic [1:0]  y;
    logic [31:0] cyc;
  } rec_t;

  rec_t q[$];
  rec_t obs[$];
  rec_t mon_r;
  int   obs_rd = 0;
  int   abort_cnt = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] pkt [0:35];
  logic [7:0] hb  [0:2];
  logic [7:0] sb  [0:3][0:6];

  logic        m_avm;
  logic [19:0] m_n, m_cts;
  logic [6:0]  m_vic;
  logic [1:0]  m_y;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (PKT_VALID) begin
      mon_r.typ  = PKT_TYPE;
      mon_r.hdr  = HDR_ECC_ERR;
      mon_r.body = BODY_ECC_ERR;
      mon_r.csum = CSUM_ERR;
      mon_r.avm  = AVMUTE;
      mon_r.n    = ACR_N;
      mon_r.cts  = ACR_CTS;
      mon_r.vic  = AVI_VIC;
      mon_r.y    = AVI_Y;
      mon_r.cyc  = 32'(cyc);
      obs.push_back(mon_r);
    end
    if (ABORT) abort_cnt++;
  end

  function automatic logic [7:0] tb_step(input logic [7:0] e, input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      if (e[0] ^ d[i]) e = (e >> 1) ^ 8'h83;
      else e = e >> 1;
    end
    return e;
  endfunction

  task automatic clear_pkt();
    for (int i = 0; i < 3; i++) hb[i] = 8'h00;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 7; i++) sb[k][i] = 8'h00;
  endtask

  task automatic set_pb(input int j, input logic [7:0] v);
    sb[j / 7][j % 7] = v;
  endtask

  task automatic fix_csum();
    logic [7:0] s;
    int len;
    set_pb(0, 8'h00);
    s = hb[0] + hb[1] + hb[2];
    len = int'(hb[2][4:0]);
    for (int j = 1; j <= len && j < 28; j++) s = s + sb[j / 7][j % 7];
    set_pb(0, 8'h00 - s);
  endtask

  task automatic build();
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < 3; i++) begin
      pkt[i] = hb[i];
      e = tb_step(e, hb[i]);
    end
    pkt[3] = e;
    for (int k = 0; k < 4; k++) begin
      e = 8'h00;
      for (int i = 0; i < 7; i++) begin
        pkt[4 + 8 * k + i] = sb[k][i];
        e = tb_step(e, sb[k][i]);
      end
      pkt[11 + 8 * k] = e;
    end
  endtask

  task automatic push_exp();
    rec_t r;
    logic [7:0] e, s;
    int len;
    r.typ = pkt[0];
    e = 8'h00;
    for (int i = 0; i < 3; i++) e = tb_step(e, pkt[i]);
    r.hdr = (e !== pkt[3]);
    for (int k = 0; k < 4; k++) begin
      e = 8'h00;
      for (int i = 0; i < 7; i++) e = tb_step(e, pkt[4 + 8 * k + i]);
      r.body[k] = (e !== pkt[11 + 8 * k]);
    end
    len = int'(pkt[2][4:0]);
    s = pkt[0] + pkt[1] + pkt[2];
    for (int j = 0; j <= len && j < 28; j++) s = s + pkt[4 + 8 * (j / 7) + j % 7];
    r.csum = pkt[0][7] && (len > MAX_IF_LEN || s != 8'h00);
    if (!r.hdr && r.body == 4'd0 && !r.csum) begin
      if (pkt[0] == 8'h03) begin
        if (pkt[4][0] && !pkt[4][4]) m_avm = 1'b1;
        if (pkt[4][4] && !pkt[4][0]) m_avm = 1'b0;
      end
      if (pkt[0] == 8'h01) begin
        m_cts = {pkt[5][3:0], pkt[6], pkt[7]};
        m_n   = {pkt[8][3:0], pkt[9], pkt[10]};
      end
      if (pkt[0] == 8'h82) begin
        m_y   = pkt[5][6:5];
        m_vic = pkt[8][6:0];
      end
    end
    r.avm = m_avm;
    r.n   = m_n;
    r.cts = m_cts;
    r.vic = m_vic;
    r.y   = m_y;
    r.cyc = 32'(cyc + 1);
    q.push_back(r);
  endtask

  task automatic send(input int nbytes, input bit gaps);
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        repeat (g) begin
          @(posedge CLK); #1;
          BYTE_VALID = 1'b0;
          PKT_START  = 1'($urandom_range(0, 1));
          BYTE_IN    = 8'($urandom);
        end
      end
      @(posedge CLK); #1;
      BYTE_VALID = 1'b1;
      PKT_START  = (i == 0);
      BYTE_IN    = pkt[i];
    end
    if (nbytes == 36) push_exp();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      BYTE_VALID = 1'b0;
      PKT_START  = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++;
    if ({PKT_VALID, ABORT, PKT_TYPE, HDR_ECC_ERR, BODY_ECC_ERR, CSUM_ERR} !== 16'h0) begin
      failures++;
      $display("FAIL reset_status got=%h want=0",
               {PKT_VALID, ABORT, PKT_TYPE, HDR_ECC_ERR, BODY_ECC_ERR, CSUM_ERR});
    end
    checks++;
    if ({AVMUTE, ACR_N, ACR_CTS, AVI_VIC, AVI_Y} !== 50'h0) begin
      failures++;
      $display("FAIL reset_regs got=%h want=0", {AVMUTE, ACR_N, ACR_CTS, AVI_VIC, AVI_Y});
    end
  endtask

  task automatic test_null();
    rec_t e, o;
    clear_pkt();
    build();
    send(36, 1'b0);
    idle(4);
    checks++;
    if ({PKT_TYPE, HDR_ECC_ERR, BODY_ECC_ERR, CSUM_ERR} !== 14'h0) begin
      failures++;
      $display("FAIL null_status got=%h want=0", {PKT_TYPE, HDR_ECC_ERR, BODY_ECC_ERR, CSUM_ERR});
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL null_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL null_pkt got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_rd != obs.size()) begin
      failures++;
      $display("FAIL null_extra pulses got=%0d want=%0d", obs.size(), obs_rd);
      obs_rd = obs.size();
    end
  endtask

  task automatic test_gcp();
    rec_t e, o;
    logic [7:0] vals [0:4];
    logic       want [0:4];
    vals = '{8'h01, 8'h10, 8'h01, 8'h11, 8'h00};
    want = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      clear_pkt();
      hb[0] = 8'h03;
      for (int k = 0; k < 4; k++) sb[k][0] = vals[i];
      build();
      send(36, 1'b0);
      idle(3);
      checks++;
      if (AVMUTE !== want[i]) begin
        failures++;
        $display("FAIL gcp_avmute sb0=%h got=%b want=%b", vals[i], AVMUTE, want[i]);
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL gcp_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL gcp_pkt got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_rd != obs.size()) begin
      failures++;
      $display("FAIL gcp_extra pulses got=%0d want=%0d", obs.size(), obs_rd);
      obs_rd = obs.size();
    end
  endtask

  task automatic test_acr();
    rec_t e, o;
    clear_pkt();
    hb[0] = 8'h01;
    sb[0][1] = 8'h01; sb[0][2] = 8'h22; sb[0][3] = 8'h0A;
    sb[0][4] = 8'h00; sb[0][5] = 8'h18; sb[0][6] = 8'h00;
    build();
    send(36, 1'b0);
    idle(3);
    checks++;
    if ({ACR_CTS, ACR_N} !== {20'h1220A, 20'h01800}) begin
      failures++;
      $display("FAIL acr_regs got cts=%h n=%h want cts=1220a n=01800", ACR_CTS, ACR_N);
    end
    build();
    pkt[6] = pkt[6] ^ 8'h01;
    send(36, 1'b0);
    idle(3);
    checks++;
    if ({BODY_ECC_ERR, ACR_CTS, ACR_N} !== {4'b0001, 20'h1220A, 20'h01800}) begin
      failures++;
      $display("FAIL acr_ecc_err got err=%b cts=%h n=%h want err=0001 cts=1220a n=01800",
               BODY_ECC_ERR, ACR_CTS, ACR_N);
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL acr_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL acr_pkt got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_rd != obs.size()) begin
      failures++;
      $display("FAIL acr_extra pulses got=%0d want=%0d", obs.size(), obs_rd);
      obs_rd = obs.size();
    end
  endtask

  task automatic test_avi();
    rec_t e, o;
    clear_pkt();
    hb[0] = 8'h82; hb[1] = 8'h02; hb[2] = 8'h0D;
    set_pb(1, 8'h00);
    set_pb(4, 8'd16);
    fix_csum();
    build();
    send(36, 1'b0);
    idle(3);
    checks++;
    if ({CSUM_ERR, AVI_VIC, AVI_Y} !== {1'b0, 7'd16, 2'd0}) begin
      failures++;
      $display("FAIL avi_vic16 got csum=%b vic=%0d y=%0d want csum=0 vic=16 y=0",
               CSUM_ERR, AVI_VIC, AVI_Y);
    end
    set_pb(4, 8'd5);
    fix_csum();
    set_pb(0, sb[0][0] + 8'h01);
    build();
    send(36, 1'b0);
    idle(3);
    checks++;
    if ({CSUM_ERR, AVI_VIC} !== {1'b1, 7'd16}) begin
      failures++;
      $display("FAIL avi_csum_err got csum=%b vic=%0d want csum=1 vic=16", CSUM_ERR, AVI_VIC);
    end
    set_pb(1, 8'h40);
    set_pb(4, 8'd4);
    fix_csum();
    build();
    send(36, 1'b0);
    idle(3);
    checks++;
    if ({AVI_VIC, AVI_Y} !== {7'd4, 2'd2}) begin
      failures++;
      $display("FAIL avi_y got vic=%0d y=%0d want vic=4 y=2", AVI_VIC, AVI_Y);
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL avi_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL avi_pkt got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_rd != obs.size()) begin
      failures++;
      $display("FAIL avi_extra pulses got=%0d want=%0d", obs.size(), obs_rd);
      obs_rd = obs.size();
    end
  endtask

  task automatic test_hdr_len();
    rec_t e, o;
    clear_pkt();
    hb[0] = 8'h03;
    sb[0][0] = 8'h10;
    build();
    pkt[1] = pkt[1] ^ 8'h04;
    send(36, 1'b0);
    idle(3);
    checks++;
    if ({HDR_ECC_ERR, AVMUTE} !== 2'b11) begin
      failures++;
      $display("FAIL hdr_ecc_err got err=%b avmute=%b want err=1 avmute=1", HDR_ECC_ERR, AVMUTE);
    end
    for (int n = 27; n <= 28; n++) begin
      clear_pkt();
      hb[0] = 8'h83; hb[1] = 8'h01; hb[2] = 8'(n);
      for (int j = 1; j < 28; j++) set_pb(j, 8'(j * 3));
      fix_csum();
      build();
      send(36, 1'b0);
      idle(3);
      checks++;
      if (CSUM_ERR !== (n > MAX_IF_LEN)) begin
        failures++;
        $display("FAIL if_len len=%0d got csum=%b want=%b", n, CSUM_ERR, n > MAX_IF_LEN);
      end
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL hdr_len_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL hdr_len_pkt got=%h want=%h", o, e); end
      end
    end
    checks++;
    if (obs_rd != obs.size()) begin
      failures++;
      $display("FAIL hdr_len_extra pulses got=%0d want=%0d", obs.size(), obs_rd);
      obs_rd = obs.size();
    end
  endtask

  task automatic test_abort(input bit gaps);
    rec_t e, o;
    int a0, v0;
    a0 = abort_cnt;
    v0 = obs.size();
    clear_pkt();
    build();
    send(20, gaps);
    send(36, gaps);
    idle(4);
    checks++;
    if (abort_cnt - a0 != 1) begin
      failures++;
      $display("FAIL abort_pulse gaps=%0d got=%0d want=1", gaps, abort_cnt - a0);
    end
    checks++;
    if (obs.size() - v0 != 1) begin
      failures++;
      $display("FAIL abort_valid_count gaps=%0d got=%0d want=1", gaps, obs.size() - v0);
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL abort_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL abort_pkt got=%h want=%h", o, e); end
      end
    end
    obs_rd = obs.size();
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    int v0;
    v0 = obs.size();
    clear_pkt();
    hb[0] = 8'h03;
    sb[0][0] = 8'h01;
    build();
    send(36, 1'b0);
    clear_pkt();
    hb[0] = 8'h01;
    sb[0][1] = 8'h0F; sb[0][2] = 8'hA5; sb[0][3] = 8'h3C;
    sb[0][4] = 8'h07; sb[0][5] = 8'h12; sb[0][6] = 8'h34;
    build();
    send(36, 1'b0);
    clear_pkt();
    hb[0] = 8'h82; hb[1] = 8'h02; hb[2] = 8'h0D;
    set_pb(1, 8'h20);
    set_pb(4, 8'd97);
    fix_csum();
    build();
    send(36, 1'b0);
    idle(4);
    checks++;
    if ({ACR_CTS, ACR_N, AVI_VIC, AVI_Y} !== {20'hFA53C, 20'h71234, 7'd97, 2'd1}) begin
      failures++;
      $display("FAIL b2b_regs got cts=%h n=%h vic=%0d y=%0d want cts=fa53c n=71234 vic=97 y=1",
               ACR_CTS, ACR_N, AVI_VIC, AVI_Y);
    end
    checks++;
    if (obs.size() - v0 != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=3", obs.size() - v0);
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL b2b_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL b2b_pkt got=%h want=%h", o, e); end
      end
    end
    obs_rd = obs.size();
  endtask

  task automatic test_reset_mid();
    rec_t e, o;
    int a0, v0;
    a0 = abort_cnt;
    clear_pkt();
    hb[0] = 8'h03;
    sb[0][0] = 8'h01;
    build();
    send(10, 1'b0);
    @(posedge CLK); #1;
    RSTN = 1'b0;
    BYTE_VALID = 1'b0;
    PKT_START = 1'b0;
    m_avm = 1'b0; m_n = '0; m_cts = '0; m_vic = '0; m_y = '0;
    @(negedge CLK);
    checks++;
    if ({AVMUTE, ACR_N, ACR_CTS, AVI_VIC, AVI_Y, PKT_TYPE} !== 58'h0) begin
      failures++;
      $display("FAIL mid_reset_regs got=%h want=0",
               {AVMUTE, ACR_N, ACR_CTS, AVI_VIC, AVI_Y, PKT_TYPE});
    end
    @(posedge CLK); #1;
    RSTN = 1'b1;
    idle(2);
    v0 = obs.size();
    send(36, 1'b0);
    idle(4);
    checks++;
    if (abort_cnt != a0) begin
      failures++;
      $display("FAIL mid_reset_abort got=%0d want=0", abort_cnt - a0);
    end
    checks++;
    if (obs.size() - v0 != 1) begin
      failures++;
      $display("FAIL mid_reset_count got=%0d want=1", obs.size() - v0);
    end
    while (q.size() > 0) begin
      e = q.pop_front(); checks++;
      if (obs_rd >= obs.size()) begin
        failures++; $display("FAIL mid_reset_pkt missing PKT_VALID want=%h", e);
      end else begin
        o = obs[obs_rd]; obs_rd++;
        if (o !== e) begin failures++; $display("FAIL mid_reset_pkt got=%h want=%h", o, e); end
      end
    end
    obs_rd = obs.size();
  endtask

  initial begin
    RSTN       = 1'b0;
    BYTE_VALID = 1'b0;
    PKT_START  = 1'b0;
    BYTE_IN    = 8'h00;
    m_avm = 1'b0; m_n = '0; m_cts = '0; m_vic = '0; m_y = '0;
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    test_reset();
    test_null();
    test_gcp();
    test_acr();
    test_avi();
    test_hdr_len();
    test_abort(1'b0);
    test_abort(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
